// File: rtl/y86_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported, fixed-latency memory bus.
// Port 0 serves the y86 core, port 1 the DMA/debug loader. One transaction is in
// flight at a time; writes take one bus cycle and reads wait RD_LAT cycles for data.
module y86_mem_arbiter #(
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned RD_LAT = 1   // legal 1..7
) (
   input  logic          clk,
   input  logic          rst,       // synchronous, active low
   // port 0
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   // port 1
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   // shared read data
   output logic [DW-1:0] rdata,
   // memory side
   output logic [AW-1:0] mem_A,
   output logic          mem_RE,
   output logic          mem_WE,
   output logic [DW-1:0] mem_out,
   input  logic [DW-1:0] mem_in,
   // status
   output logic          busy,
   output logic          owner
);

   typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

   // Wait counter preload: counts down to 0 in the cycle mem_in is valid.
   localparam logic [2:0] CntInit = 3'(RD_LAT - 1);

   state_e          state_q, state_d;
   logic            last_q, last_d;
   logic            owner_q, owner_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            rvalid_q, rvalid_d;
   logic            sel;
   logic            access;

   // State register with synchronous active-low reset; in-flight work is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Next-state: arbitrate in IDLE, one ACCESS cycle, then count down read latency.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      // Both requesting: pick the port that did not win last time.
      sel      = (req0 && req1) ? ~last_q : req1;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               we_d    = sel ? we1    : we0;
               addr_d  = sel ? addr1  : addr0;
               wdata_d = sel ? wdata1 : wdata0;
               last_d  = sel;
               owner_d = sel;
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (we_q) begin
               state_d = StIdle;
            end else begin
               cnt_d   = CntInit;
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 3'd0) begin
               rdata_d  = mem_in;
               rvalid_d = 1'b1;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decode from registered state only; the bus is idle-zero outside ACCESS.
   always_comb begin
      access  = (state_q == StAccess);
      gnt0    = access && !owner_q;
      gnt1    = access && owner_q;
      rvalid0 = rvalid_q && !owner_q;
      rvalid1 = rvalid_q && owner_q;
      rdata   = rdata_q;
      mem_A   = access ? addr_q : '0;
      mem_WE  = access && we_q;
      mem_RE  = access && !we_q;
      mem_out = (access && we_q) ? wdata_q : '0;
      busy    = (state_q != StIdle);
      owner   = owner_q;
   end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter with RD_LAT=2 and a small delayed-read memory model.
module tb_y86_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_A;
   logic          mem_RE, mem_WE;
   logic [DW-1:0] mem_out, mem_in;
   logic          busy, owner;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   y86_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
      .rdata(rdata), .mem_A(mem_A), .mem_RE(mem_RE), .mem_WE(mem_WE),
      .mem_out(mem_out), .mem_in(mem_in), .busy(busy), .owner(owner)
   );

   // Memory model: data for a read strobed in cycle A is presented only in cycle A+2.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_pipe0, rd_pipe1;
   logic          rv_pipe0, rv_pipe1;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 32'h1234_5678;
      rv_pipe0 = 1'b0;
      rv_pipe1 = 1'b0;
   end

   always @(posedge clk) begin
      if (mem_WE) mem[mem_A[7:0]] <= mem_out;
      rd_pipe0 <= mem[mem_A[7:0]];
      rv_pipe0 <= mem_RE;
      rd_pipe1 <= rd_pipe0;
      rv_pipe1 <= rv_pipe0;
   end

   assign mem_in = rv_pipe1 ? rd_pipe1 : 32'hBAD0_BAD0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 32'h80; wdata0 = 32'hA5A5;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

      // 1: reset held 3 cycles with req0 high
      step(); chk("rst_busy_c1", {31'd0, busy}, 0);
      step(); chk("rst_busy_c2", {31'd0, busy}, 0);
      step();
      chk("rst_gnt0", {31'd0, gnt0}, 0);
      chk("rst_gnt1", {31'd0, gnt1}, 0);
      chk("rst_rvalid", {30'd0, rvalid0, rvalid1}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_memA", mem_A, 0);
      chk("rst_memout", mem_out, 0);
      chk("rst_strobes", {30'd0, mem_RE, mem_WE}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_owner", {31'd0, owner}, 0);
      rst = 1'b1;
      step();
      chk("t1_gnt0", {31'd0, gnt0}, 1);
      chk("t1_memWE", {31'd0, mem_WE}, 1);
      chk("t1_memA", mem_A, 32'h80);
      chk("t1_busy", {31'd0, busy}, 1);
      req0 = 1'b0;
      step();
      chk("t1_idle_busy", {31'd0, busy}, 0);
      chk("t1_idle_memA", mem_A, 0);

      // 2: port 1 write
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hDEAD_BEEF;
      step();
      chk("t2_gnt1", {31'd0, gnt1}, 1);
      chk("t2_gnt0", {31'd0, gnt0}, 0);
      chk("t2_strobes", {30'd0, mem_RE, mem_WE}, 1);
      chk("t2_memA", mem_A, 32'h40);
      chk("t2_memout", mem_out, 32'hDEAD_BEEF);
      chk("t2_owner", {31'd0, owner}, 1);
      req1 = 1'b0;
      step();
      chk("t2_after_WE", {31'd0, mem_WE}, 0);
      chk("t2_no_rvalid", {30'd0, rvalid0, rvalid1}, 0);
      chk("t2_busy", {31'd0, busy}, 0);

      // 3: port 0 read at 0x10, RD_LAT=2
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      step();
      chk("t3_gnt0", {31'd0, gnt0}, 1);
      chk("t3_strobes", {30'd0, mem_RE, mem_WE}, 2);
      chk("t3_memout", mem_out, 0);
      chk("t3_memA", mem_A, 32'h10);
      req0 = 1'b0;
      step();
      chk("t3_a1_rvalid", {31'd0, rvalid0}, 0);
      chk("t3_a1_RE", {31'd0, mem_RE}, 0);
      chk("t3_a1_busy", {31'd0, busy}, 1);
      step();
      chk("t3_a2_rvalid", {31'd0, rvalid0}, 0);
      chk("t3_a2_busy", {31'd0, busy}, 1);
      step();
      chk("t3_a3_rvalid0", {31'd0, rvalid0}, 1);
      chk("t3_a3_rvalid1", {31'd0, rvalid1}, 0);
      chk("t3_a3_rdata", rdata, 32'h1234_5678);
      chk("t3_a3_busy", {31'd0, busy}, 0);
      step();
      chk("t3_a4_rvalid0", {31'd0, rvalid0}, 0);
      chk("t3_a4_rdata_hold", rdata, 32'h1234_5678);

      // 4: both ports hold req, writes; order 0,1,0,1... from reset
      rst = 1'b0;
      step();
      chk("t4_rst_rdata", rdata, 0);
      rst = 1'b1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h100;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h200;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t4_gnt", {30'd0, gnt1, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd2);
         chk("t4_memA", mem_A, (i % 2 == 0) ? 32'h20 : 32'h30);
         chk("t4_memout", mem_out, (i % 2 == 0) ? 32'h100 : 32'h200);
         if (i == 7) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         step();
         chk("t4_idle", {30'd0, busy, mem_WE}, 0);
      end

      // 5: reset during WAIT of a port 1 read
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
      step();
      chk("t5_gnt1", {31'd0, gnt1}, 1);
      chk("t5_RE", {31'd0, mem_RE}, 1);
      req1 = 1'b0;
      step();
      chk("t5_wait_busy", {31'd0, busy}, 1);
      rst = 1'b0;
      step();
      chk("t5_rst_busy", {31'd0, busy}, 0);
      chk("t5_rst_rvalid1", {31'd0, rvalid1}, 0);
      chk("t5_rst_owner", {31'd0, owner}, 0);
      rst = 1'b1;
      step();
      chk("t5_no_rvalid", {30'd0, rvalid0, rvalid1}, 0);
      chk("t5_rdata", rdata, 0);

      // 6: port 0 reads back the port 1 write at 0x40
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
      step();
      chk("t6_gnt0", {31'd0, gnt0}, 1);
      chk("t6_memA", mem_A, 32'h40);
      req0 = 1'b0;
      step();
      step();
      chk("t6_a2_rvalid0", {31'd0, rvalid0}, 0);
      step();
      chk("t6_rvalid0", {31'd0, rvalid0}, 1);
      chk("t6_rdata", rdata, 32'hDEAD_BEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
